ppu_row_buffer: RTL and testbench

Double-buffered scanline row store between the PPU row renderer and the HDMI video output. The renderer streams one row of 10-bit palette-indexed pixels into the back bank over a valid/ready handshake. The video output reads the front bank by address. Each `rowram_swap` pulse from the video output exchanges the banks and starts the next fill, and a fill that is still incomplete at swap time is flagged as an underrun.

---
 rtl/ppu_row_buffer.sv | 143 ++++++++++++++
 tb/tb_ppu_row_buffer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_row_buffer.sv
// ppu_row_buffer
// Double-buffered scanline store. The renderer fills the back bank over a valid/ready
// handshake while the video output reads the front bank by address. A rowram_swap
// pulse exchanges the banks and starts the next fill. A fill that is still incomplete
// at swap time is reported as an underrun.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rowram_swap       one-cycle pulse: swap banks and start a fill
//   rowram_rdaddr     front-bank read address
//   rowram_rddata     registered read data (0 for addresses past the row)
//   pix_valid/ready   renderer pixel handshake
//   pix_data          pixel (palette index)
//   row_start         one-cycle pulse telling the renderer to begin a row
//   row_done          level, current fill complete
//   underrun          one-cycle pulse when a swap hits an incomplete fill
//   underrun_count    saturating underrun counter
module ppu_row_buffer #(
    parameter int ROW_PIXELS = 320,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rowram_swap,
    input  logic [ADDR_W-1:0] rowram_rdaddr,
    output logic [DATA_W-1:0] rowram_rddata,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              row_start,
    output logic              row_done,
    output logic              underrun,
    output logic [7:0]        underrun_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_PIXELS - 1);

    state_t            state_q, state_d;
    logic              bank_sel_q, bank_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              row_start_q, row_start_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        underrun_count_q, underrun_count_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;

    logic              accept;
    logic              last_accept;

    // Both banks; contents are deliberately not reset.
    logic [DATA_W-1:0] bank_mem [0:1][0:ROW_PIXELS-1];

    assign accept      = pix_valid & pix_ready;
    assign last_accept = accept & (wr_addr_q == LAST_ADDR);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (rowram_swap) begin
            state_d = ST_FILL;
        end else if (state_q == ST_FILL && last_accept) begin
            state_d = ST_DONE;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pix_ready = (state_q == ST_FILL);
        row_done  = (state_q == ST_DONE);
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        bank_sel_d       = bank_sel_q;
        wr_addr_d        = wr_addr_q;
        row_start_d      = rowram_swap;
        underrun_d       = 1'b0;
        underrun_count_d = underrun_count_q;
        rddata_d         = '0;

        if (rowram_swap) begin
            bank_sel_d = ~bank_sel_q;
            wr_addr_d  = '0;
        end else if (accept && !last_accept) begin
            wr_addr_d = wr_addr_q + 1'b1;
        end

        // A final pixel accepted on the swap edge completes the row, so no underrun.
        if (rowram_swap && state_q == ST_FILL && !last_accept) begin
            underrun_d = 1'b1;
            if (underrun_count_q != 8'hFF) begin
                underrun_count_d = underrun_count_q + 8'd1;
            end
        end

        // Reads use the pre-toggle bank_sel, i.e. the front bank as of this cycle.
        if (int'(rowram_rdaddr) < ROW_PIXELS) begin
            rddata_d = bank_mem[bank_sel_q][rowram_rdaddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_q       <= 1'b0;
            wr_addr_q        <= '0;
            row_start_q      <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= 8'd0;
            rddata_q         <= '0;
        end else begin
            bank_sel_q       <= bank_sel_d;
            wr_addr_q        <= wr_addr_d;
            row_start_q      <= row_start_d;
            underrun_q       <= underrun_d;
            underrun_count_q <= underrun_count_d;
            rddata_q         <= rddata_d;
        end
    end

    // Writes go to the back bank as of this cycle, even on a swap edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_mem[~bank_sel_q][wr_addr_q] <= pix_data;
        end
    end

    assign rowram_rddata  = rddata_q;
    assign row_start      = row_start_q;
    assign underrun       = underrun_q;
    assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_ppu_row_buffer.sv
module tb_ppu_row_buffer;
    localparam int RP = 320;
    localparam int AW = 9;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rowram_swap;
    logic [AW-1:0] rowram_rdaddr;
    logic [DW-1:0] rowram_rddata;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          row_start;
    logic          row_done;
    logic          underrun;
    logic [7:0]    underrun_count;

    ppu_row_buffer #(.ROW_PIXELS(RP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .rowram_swap(rowram_swap),
        .rowram_rdaddr(rowram_rdaddr), .rowram_rddata(rowram_rddata),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .row_start(row_start), .row_done(row_done), .underrun(underrun),
        .underrun_count(underrun_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: two row arrays with "known" flags, a fill counter and flags.
    int  mb [2][RP];
    bit  mk [2][RP];
    bit  m_sel, m_fill, m_done, m_start, m_und, m_rdk;
    int  m_cnt, m_ucnt, m_rd;
    int  n_acc;

    typedef struct {
        bit          swap;
        bit          valid;
        logic [9:0]  data;
        logic [8:0]  addr;
        bit          e_ready;
        bit          e_start;
        bit          e_done;
        bit          e_und;
        int          e_cnt;
        int          e_rd;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sel = 0; m_fill = 0; m_done = 0; m_start = 0; m_und = 0;
        m_cnt = 0; m_ucnt = 0; m_rd = 0; m_rdk = 1;
    endtask

    task automatic tick();
        bit acc, comp;
        acc = m_fill && pix_valid;
        if (int'(rowram_rdaddr) >= RP) begin
            m_rd = 0; m_rdk = 1;
        end else begin
            m_rd = mb[m_sel][rowram_rdaddr];
            m_rdk = mk[m_sel][rowram_rdaddr];
        end
        comp = 0;
        if (acc) begin
            mb[!m_sel][m_cnt] = int'(pix_data);
            mk[!m_sel][m_cnt] = 1;
            m_cnt++;
            n_acc++;
            comp = (m_cnt == RP);
        end
        m_start = rowram_swap;
        m_und   = rowram_swap && m_fill && !comp;
        if (m_und && m_ucnt < 255) m_ucnt++;
        if (rowram_swap) begin
            m_sel = !m_sel; m_fill = 1; m_done = 0; m_cnt = 0;
        end else if (comp) begin
            m_fill = 0; m_done = 1;
        end
        @(posedge clk);
        #1;
        chk("pix_ready", int'(pix_ready), int'(m_fill));
        chk("row_done", int'(row_done), int'(m_done));
        chk("row_start", int'(row_start), int'(m_start));
        chk("underrun", int'(underrun), int'(m_und));
        chk("underrun_count", int'(underrun_count), m_ucnt);
        if (m_rdk) chk("rowram_rddata", int'(rowram_rddata), m_rd);
    endtask

    task automatic drive(input bit sw, input bit v, input int d, input int a);
        rowram_swap   = sw;
        pix_valid     = v;
        pix_data      = DW'(d);
        rowram_rdaddr = AW'(a);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            drive(1'($urandom), 1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            @(posedge clk);
            #1;
            chk("rst_outputs_zero",
                int'({rowram_rddata, pix_ready, row_start, row_done, underrun, underrun_count}), 0);
        end
        model_reset();
        drive(0, 0, 0, 400);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        drive(0, 0, 0, 400);
        n_acc = 0;
        model_reset();

        tbl[0] = '{0, 1, 10'h011, 9'd400, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 1, 10'h022, 9'd511, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 0, 10'h000, 9'd400, 1, 1, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 10'h000, 9'd450, 1, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 1, 10'h005, 9'd400, 1, 0, 0, 0, 0, 0};
        tbl[5] = '{1, 0, 10'h000, 9'd400, 1, 1, 0, 1, 1, 0};
        tbl[6] = '{0, 0, 10'h000, 9'd400, 1, 0, 0, 0, 1, 0};

        // Reset, then the table of short idle/swap/underrun vectors.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].swap, tbl[i].valid, int'(tbl[i].data), int'(tbl[i].addr));
            tick();
            chk($sformatf("tbl%0d_ready", i), int'(pix_ready), int'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_start", i), int'(row_start), int'(tbl[i].e_start));
            chk($sformatf("tbl%0d_done", i), int'(row_done), int'(tbl[i].e_done));
            chk($sformatf("tbl%0d_underrun", i), int'(underrun), int'(tbl[i].e_und));
            chk($sformatf("tbl%0d_count", i), int'(underrun_count), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_rddata", i), int'(rowram_rddata), tbl[i].e_rd);
        end
        do_reset();

        // Full fill with pix_valid held high.
        drive(1, 0, 0, 400);
        tick();
        for (int i = 0; i < RP; i++) begin
            drive(0, 1, i & 'h3FF, int'($urandom_range(0, 511)));
            tick();
            if (i == RP - 2) chk("fill_not_done_early", int'(row_done), 0);
        end
        chk("fill_done", int'(row_done), 1);
        chk("fill_no_underrun", int'(underrun_count), 0);

        // Swap and read back while the next fill runs.
        drive(1, 0, 0, 0);
        tick();
        for (int i = 0; i < RP; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), i);
            tick();
            chk("readback", int'(rowram_rddata), i);
        end
        drive(0, 0, 0, 400);
        tick();
        chk("read_out_of_range", int'(rowram_rddata), 0);

        // Backpressure fill.
        drive(1, 0, 0, 400);
        tick();
        n_acc = 0;
        guard = 0;
        while (!row_done && guard < 5000) begin
            drive(0, 1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            tick();
            guard++;
        end
        chk("bp_completed_in_budget", int'(guard < 5000), 1);
        chk("bp_accepts", n_acc, RP);
        repeat (10) begin
            drive(0, 1, int'($urandom_range(0, 1023)), 400);
            tick();
        end
        chk("bp_no_accept_when_done", n_acc, RP);
        drive(1, 0, 0, 400);
        tick();
        for (int i = 0; i < RP; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), i);
            tick();
            chk("bp_readback", int'(rowram_rddata), mb[m_sel][i]);
        end

        // Underrun after 100 pixels.
        drive(1, 0, 0, 400);
        tick();
        for (int i = 0; i < 100; i++) begin
            drive(0, 1, 'h200 + i, 400);
            tick();
        end
        drive(1, 0, 0, 400);
        tick();
        chk("ur_pulse", int'(underrun), 1);
        chk("ur_count", int'(underrun_count), 1);
        drive(0, 0, 0, 400);
        tick();
        chk("ur_single_pulse", int'(underrun), 0);
        for (int i = 0; i < RP; i++) begin
            drive(0, 0, 0, i);
            tick();
            chk("ur_readback", int'(rowram_rddata), (i < 100) ? ('h200 + i) : mb[m_sel][i]);
        end

        // Swap coincident with the final pixel.
        for (int i = 0; i < RP - 1; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), 400);
            tick();
        end
        drive(1, 1, 'h155, 400);
        tick();
        chk("final_swap_no_underrun", int'(underrun), 0);
        chk("final_swap_count", int'(underrun_count), 1);
        drive(0, 0, 0, 319);
        tick();
        chk("final_pixel_read", int'(rowram_rddata), 'h155);

        // Swap coincident with pixel 50.
        for (int i = 0; i < 50; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), 400);
            tick();
        end
        drive(1, 1, 'h0AA, 400);
        tick();
        chk("mid_swap_underrun", int'(underrun), 1);
        chk("mid_swap_count", int'(underrun_count), 2);
        drive(0, 0, 0, 50);
        tick();
        chk("mid_pixel_read", int'(rowram_rddata), 'h0AA);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            drive(1, 1'($urandom), int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
            tick();
        end
        chk("ur_saturated", int'(underrun_count), 255);

        // Reset in the middle of a fill.
        drive(1, 0, 0, 400);
        tick();
        for (int i = 0; i < 150; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), 400);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(pix_ready), 0);
        chk("midrst_done", int'(row_done), 0);
        chk("midrst_count", int'(underrun_count), 0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, int'($urandom_range(0, 1023)), 400);
            tick();
        end
        drive(1, 0, 0, 400);
        tick();
        chk("midrst_bank_sel", int'(dut.bank_sel_q), 1);
        for (int i = 0; i < RP; i++) begin
            drive(0, 1, (i * 3) & 'h3FF, 400);
            tick();
        end
        drive(1, 0, 0, 400);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, i);
            tick();
            chk("midrst_clean_fill", int'(rowram_rddata), (i * 3) & 'h3FF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
